// File: rtl/sar_pkg.sv
// Shared types and sizing helpers for the successive-approximation search block.
package sar_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PROBE,
    S_DONE
  } sar_state_t;

  localparam int SAR_DEFAULT_N = 32;

  // Bit-index register width: enough to hold N-1, never less than one bit.
  function automatic int sar_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sar_bit_mask.sv
// One-hot decoder: turns the current bit index into the N-bit trial mask.
module sar_bit_mask #(
  parameter int N     = 32,
  parameter int IDX_W = 5
) (
  input  logic [IDX_W-1:0] bit_idx,
  output logic [N-1:0]     mask
);

  assign mask = {{(N-1){1'b0}}, 1'b1} << bit_idx;

endmodule

// File: rtl/sar_search.sv
// Binary-search controller driving an external unsigned comparator, MSB first.
// Optional early termination on equality: define SAR_EARLY_EXIT_EN (adds cmp_eq).
module sar_search
  import sar_pkg::*;
#(
  parameter int N = SAR_DEFAULT_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic [N-1:0] probe,
  output logic         probe_valid,
  input  logic         cmp_valid,
  input  logic         cmp_gt
`ifdef SAR_EARLY_EXIT_EN
  ,
  input  logic         cmp_eq
`endif
);

  localparam int IDX_W = sar_idx_w(N);

  sar_state_t       state_q, state_d;
  logic [N-1:0]     accum_q, accum_d;
  logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic [N-1:0]     mask;
  logic [N-1:0]     trial;
  logic             xact;
  logic             eq_hit;

  sar_bit_mask #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_bit_mask (
    .bit_idx (bit_idx_q),
    .mask    (mask)
  );

  assign trial       = accum_q | mask;
  assign probe_valid = (state_q == S_PROBE);
  assign busy        = probe_valid;
  assign done        = (state_q == S_DONE);
  // Gated so the probe bus reads zero whenever no search is running.
  assign probe       = probe_valid ? trial : '0;
  assign result      = accum_q;
  assign xact        = probe_valid & cmp_valid;

`ifdef SAR_EARLY_EXIT_EN
  assign eq_hit = cmp_eq;
`else
  assign eq_hit = 1'b0;
`endif

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d   = state_q;
    accum_d   = accum_q;
    bit_idx_d = bit_idx_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_PROBE;
          accum_d   = '0;
          bit_idx_d = IDX_W'(N - 1);
        end
      end
      S_PROBE: begin
        if (xact) begin
          if (eq_hit) begin
            accum_d = trial;
            state_d = S_DONE;
          end else begin
            if (!cmp_gt) accum_d = trial;
            // Index parks at zero on the last bit instead of wrapping.
            if (bit_idx_q == '0) state_d = S_DONE;
            else bit_idx_d = bit_idx_q - IDX_W'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      accum_q   <= '0;
      bit_idx_q <= IDX_W'(N - 1);
    end else begin
      state_q   <= state_d;
      accum_q   <= accum_d;
      bit_idx_q <= bit_idx_d;
    end
  end

endmodule

// File: tb/tb_sar_search.sv
// Randomized self-checking bench for sar_search (N=8 and N=32 instances).
// Honours SAR_EARLY_EXIT_EN the same way as the design.
module tb_sar_search;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // N=8 instance
  logic       start8 = 1'b0, busy8, done8, pv8, cv8 = 1'b0, gt8 = 1'b0, eq8 = 1'b0;
  logic [7:0] res8, probe8;
  // N=32 instance
  logic        start32 = 1'b0, busy32, done32, pv32, cv32 = 1'b0, gt32 = 1'b0, eq32 = 1'b0;
  logic [31:0] res32, probe32;

  sar_search #(.N(8)) u_dut8 (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start8),
    .busy        (busy8),
    .done        (done8),
    .result      (res8),
    .probe       (probe8),
    .probe_valid (pv8),
    .cmp_valid   (cv8),
    .cmp_gt      (gt8)
`ifdef SAR_EARLY_EXIT_EN
    ,
    .cmp_eq      (eq8)
`endif
  );

  sar_search #(.N(32)) u_dut32 (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start32),
    .busy        (busy32),
    .done        (done32),
    .result      (res32),
    .probe       (probe32),
    .probe_valid (pv32),
    .cmp_valid   (cv32),
    .cmp_gt      (gt32)
`ifdef SAR_EARLY_EXIT_EN
    ,
    .cmp_eq      (eq32)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: the k-th trial keeps the hidden value's bits above the trial bit
  // and sets the trial bit itself.
  function automatic logic [63:0] model_probe(input logic [63:0] h, input int n, input int k);
    int b;
    b = n - 1 - k;
    return ((h >> (b + 1)) << (b + 1)) | (64'd1 << b);
  endfunction

  function automatic int exp_xacts(input logic [63:0] h, input int n);
`ifdef SAR_EARLY_EXIT_EN
    for (int k = 0; k < n; k++)
      if (model_probe(h, n, k) == h) return k + 1;
`endif
    return n;
  endfunction

  // Responder for the N=8 instance: answers after lat8 waiting cycles.
  logic [7:0] hid8 = '0, held8 = '0;
  int         lat8 = 0, wcnt8 = 0;
  logic [7:0] xq8[$];
  logic       gq8[$];

  always @(negedge clk) begin
    if (pv8) begin
      if (wcnt8 > 0) check("probe8_stable", probe8, held8);
      if (wcnt8 >= lat8) begin
        cv8 = 1'b1;
        gt8 = (hid8 < probe8);
        eq8 = (probe8 == hid8);
        xq8.push_back(probe8);
        gq8.push_back(gt8);
        wcnt8 = 0;
      end else begin
        cv8   = 1'b0;
        held8 = probe8;
        wcnt8++;
      end
    end else begin
      cv8   = 1'b0;
      wcnt8 = 0;
    end
  end

  // Responder for the N=32 instance: fresh random latency 0..4 per transaction.
  logic [31:0] hid32 = '0;
  int          lat32 = 0, wcnt32 = 0, nx32 = 0;

  always @(negedge clk) begin
    if (pv32) begin
      if (wcnt32 >= lat32) begin
        cv32 = 1'b1;
        gt32 = (hid32 < probe32);
        eq32 = (probe32 == hid32);
        nx32++;
        wcnt32 = 0;
        lat32  = $urandom_range(0, 4);
      end else begin
        cv32 = 1'b0;
        wcnt32++;
      end
    end else begin
      cv32   = 1'b0;
      wcnt32 = 0;
    end
  end

  task automatic wait_done8(input string tag, output int cyc);
    cyc = 1;
    while (!done8 && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_done_seen"}, done8, 1'b1);
  endtask

  task automatic wait_xq8(input string tag, input int n);
    int c = 0;
    while (xq8.size() < n && c < 100) begin
      @(negedge clk);
      c++;
    end
    check({tag, "_reached"}, (xq8.size() >= n), 1'b1);
  endtask

  task automatic run8(input logic [7:0] h, input int lat, input string tag);
    int cyc, nx;
    logic [63:0] p;
    hid8 = h;
    lat8 = lat;
    xq8.delete();
    gq8.delete();
    @(negedge clk) start8 = 1'b1;
    @(negedge clk) start8 = 1'b0;
    wait_done8(tag, cyc);
    nx = exp_xacts({56'd0, h}, 8);
    check({tag, "_busy_at_done"}, busy8, 1'b0);
    check({tag, "_result"}, res8, h);
    check({tag, "_xacts"}, xq8.size(), nx);
    check({tag, "_cycles"}, cyc, nx * (lat + 1) + 1);
    for (int k = 0; k < nx && k < xq8.size(); k++) begin
      p = model_probe({56'd0, h}, 8, k);
      check({tag, "_probe"}, xq8[k], p);
      check({tag, "_gt"}, gq8[k], ({56'd0, h} < p));
    end
  endtask

  task automatic run32(input logic [31:0] h, input string tag);
    int cyc = 1;
    hid32 = h;
    nx32  = 0;
    lat32 = $urandom_range(0, 4);
    @(negedge clk) start32 = 1'b1;
    @(negedge clk) start32 = 1'b0;
    while (!done32 && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_done_seen"}, done32, 1'b1);
    check({tag, "_busy_at_done"}, busy32, 1'b0);
    check({tag, "_result"}, res32, h);
    check({tag, "_xacts"}, nx32, exp_xacts({32'd0, h}, 32));
  endtask

  initial begin
    logic [7:0] exp_p1[8];
    logic       exp_g1[8];
    logic [7:0] r8;
    int cyc;
    exp_p1 = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
    exp_g1 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy8, 1'b0);
    check("rst_done", done8, 1'b0);
    check("rst_pv", pv8, 1'b0);
    check("rst_probe", probe8, 8'h00);
    check("rst_result", res8, 8'h00);
    check("rst_result32", res32, 32'h0);
    rst_n = 1'b1;

    // 1: worked example, zero latency
    run8(8'hA5, 0, "t1");
    for (int k = 0; k < 8 && k < xq8.size(); k++) begin
      check("t1_probe_const", xq8[k], exp_p1[k]);
      check("t1_gt_const", gq8[k], exp_g1[k]);
    end
    repeat (2) @(negedge clk);
    check("t1_result_held", res8, 8'hA5);

    // 2: extremes
    run8(8'h00, 0, "t2_zero");
    foreach (gq8[k]) check("t2_zero_gt1", gq8[k], 1'b1);
    run8(8'hFF, 0, "t2_ones");
    foreach (gq8[k]) check("t2_ones_gt0", gq8[k], 1'b0);

    // 3: slow responder
    run8(8'h3C, 3, "t3");

    // 4a: start during a search is ignored
    hid8 = 8'h5B;
    lat8 = 1;
    xq8.delete();
    gq8.delete();
    @(negedge clk) start8 = 1'b1;
    @(negedge clk) start8 = 1'b0;
    wait_xq8("t4_probe4", 3);
    start8 = 1'b1;
    @(negedge clk) start8 = 1'b0;
    wait_done8("t4a", cyc);
    check("t4a_result", res8, 8'h5B);
    check("t4a_xacts", xq8.size(), 8);

    // 4b: reset in the middle of a search
    hid8 = 8'hC7;
    lat8 = 0;
    xq8.delete();
    @(negedge clk) start8 = 1'b1;
    @(negedge clk) start8 = 1'b0;
    wait_xq8("t4_probe5", 4);
    rst_n = 1'b0;
    #1;
    check("t4b_busy", busy8, 1'b0);
    check("t4b_done", done8, 1'b0);
    check("t4b_pv", pv8, 1'b0);
    check("t4b_probe", probe8, 8'h00);
    check("t4b_result", res8, 8'h00);
    @(negedge clk) rst_n = 1'b1;
    run8(8'hC7, 0, "t4b_fresh");

    // start held: restart one cycle after DONE returns to IDLE
    hid8 = 8'h3C;
    lat8 = 0;
    xq8.delete();
    @(negedge clk) start8 = 1'b1;
    @(negedge clk);
    wait_done8("held", cyc);
    @(negedge clk);
    check("held_idle_gap", busy8, 1'b0);
    @(negedge clk);
    check("held_restart", busy8, 1'b1);
    start8 = 1'b0;
    wait_done8("held2", cyc);
    check("held2_result", res8, 8'h3C);

    // 5: random sweeps
    for (int i = 0; i < 40; i++) begin
      r8 = 8'($urandom);
      run8(r8, $urandom_range(0, 2), "t5_n8");
    end
    run32(32'h0000_0000, "t5_zero");
    run32(32'hFFFF_FFFF, "t5_ones");
    for (int i = 0; i < 250; i++) run32($urandom, "t5_n32");

    // 6: early-exit candidate
    run8(8'h80, 0, "t6");
`ifdef SAR_EARLY_EXIT_EN
    check("t6_xacts_const", xq8.size(), 1);
`else
    check("t6_xacts_const", xq8.size(), 8);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
